pipe_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the five-stage MIPS pipeline. It drives the enable and bubble-insert controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves load-use hazards, taken branches reported by the EX/MEM stage, and variable-latency data-memory accesses. A watchdog halts the pipeline if memory never answers.

---
 rtl/pipe_hazard_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Central stall/flush sequencer for the five-stage MIPS pipeline. It drives
// the load enables and bubble-insert (flush) controls of the PC, IF/ID,
// ID/EX, EX/MEM and MEM/WB registers. It resolves three kinds of event:
// load-use hazards, taken branches reported by EX/MEM, and variable-latency
// data-memory accesses. A watchdog halts the pipeline when memory stalls
// for MEM_TIMEOUT consecutive cycles.
//
// Parameters
//   REG_W        register-index width
//   MEM_TIMEOUT  consecutive memory-stall cycles before HALT (2..255)
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   id_rs, id_rt          source registers of the instruction in ID
//   id_uses_rt            instruction in ID reads rt
//   ex_mem_read, ex_rd    instruction in EX is a load, and its destination
//   mem_branch, mem_zero  EX/MEM branch and zero flags (taken = both)
//   mem_access            EX/MEM instruction accesses data memory
//   dmem_ready            data memory completes the access this cycle
//   pc_en .. ex_mem_en    register load enables
//   *_flush               load a bubble into that register
//   pc_sel_branch         PC takes the EX/MEM branch target
//   mem_timeout           sticky watchdog flag
//   state                 RUN=0, MEM_WAIT=1, HALT=2
//   stall_cycles          (only with STALL_CNT_EN) saturating count of
//                         cycles in which the PC was held
//
// Optional feature macro: STALL_CNT_EN
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int REG_W       = 5,
    parameter int MEM_TIMEOUT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             mem_branch,
    input  logic             mem_zero,
    input  logic             mem_access,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             mem_wb_flush,
    output logic             pc_sel_branch,
    output logic             mem_timeout,
`ifdef STALL_CNT_EN
    output logic [31:0]      stall_cycles,
`endif
    output logic [1:0]       state
);

    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] MEM_WAIT = 2'd1;
    localparam logic [1:0] HALT     = 2'd2;

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             taken;
    logic             load_use;
    logic             mem_stall;
    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_q;

    assign taken     = mem_branch & mem_zero;
    assign load_use  = ex_mem_read & (ex_rd != '0) &
                       ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt)));
    assign mem_stall = mem_access & ~dmem_ready;

    assign mem_timeout = timeout_q;

    // Control outputs. Reset wins over everything and loads bubbles
    // everywhere; HALT freezes the front of the pipe and keeps draining
    // bubbles into MEM/WB. In RUN and MEM_WAIT a memory stall outranks a
    // taken branch, which in turn discards any load-use hazard because the
    // instruction in ID is about to be flushed anyway.
    always_comb begin
        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        id_ex_en      = 1'b1;
        ex_mem_en     = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_flush  = 1'b0;
        mem_wb_flush  = 1'b0;
        pc_sel_branch = 1'b0;
        if (!rst_n) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            mem_wb_flush = 1'b1;
        end else if (state == HALT) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_flush = 1'b1;
        end else if (mem_stall) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_flush = 1'b1;
        end else if (taken) begin
            pc_sel_branch = 1'b1;
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
            ex_mem_flush  = 1'b1;
        end else if (load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    // Sequencer and watchdog. wait_cnt counts consecutive stalled cycles,
    // the RUN cycle that starts the stall being number one, so HALT is
    // reached on the edge that closes stall cycle MEM_TIMEOUT. Once in
    // HALT only reset gets the pipeline going again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (mem_stall) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= CNT_ONE;
                    end else begin
                        wait_cnt <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (!mem_stall) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == CNT_LAST) begin
                        state     <= HALT;
                        timeout_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_ONE;
                    end
                end
                HALT: begin
                    state     <= HALT;
                    timeout_q <= 1'b1;
                end
                default: begin
                    state    <= RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

`ifdef STALL_CNT_EN
    // Performance counter: one tick per cycle the PC was held while the
    // pipeline is alive. Saturates rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if ((state != HALT) && !pc_en &&
                     (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//
// Directed bench for pipe_hazard_ctrl (MEM_TIMEOUT = 8). A table of input
// records with hand-computed enable/flush/branch-select values covers the
// combinational priority logic; hand-written sequences cover the memory
// wait, watchdog, asynchronous reset and (with STALL_CNT_EN) the stall
// counter.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       mread;
        logic [4:0] rd;
        logic       branch;
        logic       zero;
        logic       access;
        logic       ready;
    } in_t;

    typedef struct {
        in_t        in;
        logic [3:0] en;
        logic [3:0] fl;
        logic       sel;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rt;
    logic        ex_mem_read;
    logic [4:0]  ex_rd;
    logic        mem_branch;
    logic        mem_zero;
    logic        mem_access;
    logic        dmem_ready;
    logic        pc_en;
    logic        if_id_en;
    logic        id_ex_en;
    logic        ex_mem_en;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        ex_mem_flush;
    logic        mem_wb_flush;
    logic        pc_sel_branch;
    logic        mem_timeout;
    logic [1:0]  state;
`ifdef STALL_CNT_EN
    logic [31:0] stall_cycles;
`endif

    int compares = 0;
    int fails    = 0;

    vec_t vecs[12];
    in_t  idle;
    in_t  stall;
    in_t  lu;

    pipe_hazard_ctrl #(.REG_W(5), .MEM_TIMEOUT(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_uses_rt    (id_uses_rt),
        .ex_mem_read   (ex_mem_read),
        .ex_rd         (ex_rd),
        .mem_branch    (mem_branch),
        .mem_zero      (mem_zero),
        .mem_access    (mem_access),
        .dmem_ready    (dmem_ready),
        .pc_en         (pc_en),
        .if_id_en      (if_id_en),
        .id_ex_en      (id_ex_en),
        .ex_mem_en     (ex_mem_en),
        .if_id_flush   (if_id_flush),
        .id_ex_flush   (id_ex_flush),
        .ex_mem_flush  (ex_mem_flush),
        .mem_wb_flush  (mem_wb_flush),
        .pc_sel_branch (pc_sel_branch),
        .mem_timeout   (mem_timeout),
`ifdef STALL_CNT_EN
        .stall_cycles  (stall_cycles),
`endif
        .state         (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic in_t mkIn(logic [4:0] rs, logic [4:0] rt, logic uses,
                                 logic mread, logic [4:0] rd, logic br,
                                 logic z, logic acc, logic rdy);
        in_t v;
        v.rs      = rs;
        v.rt      = rt;
        v.uses_rt = uses;
        v.mread   = mread;
        v.rd      = rd;
        v.branch  = br;
        v.zero    = z;
        v.access  = acc;
        v.ready   = rdy;
        return v;
    endfunction

    function automatic vec_t mkVec(in_t i, logic [3:0] en, logic [3:0] fl,
                                   logic sel);
        vec_t v;
        v.in  = i;
        v.en  = en;
        v.fl  = fl;
        v.sel = sel;
        return v;
    endfunction

    task automatic driveInputs(input in_t v);
        id_rs       = v.rs;
        id_rt       = v.rt;
        id_uses_rt  = v.uses_rt;
        ex_mem_read = v.mread;
        ex_rd       = v.rd;
        mem_branch  = v.branch;
        mem_zero    = v.zero;
        mem_access  = v.access;
        dmem_ready  = v.ready;
    endtask

    // New inputs are presented just after a rising edge and sampled on the
    // following falling edge.
    task automatic applyStimulus(input in_t v);
        @(posedge clk);
        #1;
        driveInputs(v);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        compares++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] enBits();
        return {pc_en, if_id_en, id_ex_en, ex_mem_en};
    endfunction

    function automatic logic [3:0] flBits();
        return {if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};
    endfunction

    initial begin
        idle  = mkIn(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        stall = mkIn(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        lu    = mkIn(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);

        // rs rt uses mread rd br z acc rdy | en fl sel
        vecs[0]  = mkVec(idle, 4'hF, 4'h0, 1'b0);
        vecs[1]  = mkVec(lu, 4'b0011, 4'b0100, 1'b0);
        vecs[2]  = mkVec(mkIn(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0), 4'hF, 4'h0, 1'b0);
        vecs[3]  = mkVec(mkIn(5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0), 4'b0011, 4'b0100, 1'b0);
        vecs[4]  = mkVec(mkIn(5'd3, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0), 4'hF, 4'h0, 1'b0);
        vecs[5]  = mkVec(mkIn(5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0), 4'hF, 4'h0, 1'b0);
        vecs[6]  = mkVec(mkIn(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0), 4'hF, 4'b1110, 1'b1);
        vecs[7]  = mkVec(mkIn(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0), 4'hF, 4'h0, 1'b0);
        vecs[8]  = mkVec(mkIn(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0), 4'hF, 4'h0, 1'b0);
        vecs[9]  = mkVec(mkIn(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1), 4'hF, 4'b1110, 1'b1);
        vecs[10] = mkVec(mkIn(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0), 4'h0, 4'b0001, 1'b0);
        vecs[11] = mkVec(mkIn(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 1'b1), 4'b0011, 4'b0100, 1'b0);

        // Reset state
        rst_n = 1'b0;
        driveInputs(idle);
        #12;
        checkOutput("reset_state", 32'(state), 32'd0);
        checkOutput("reset_en", 32'(enBits()), 32'h0);
        checkOutput("reset_flush", 32'(flBits()), 32'hF);
        checkOutput("reset_sel_timeout", 32'({pc_sel_branch, mem_timeout}), 32'd0);
`ifdef STALL_CNT_EN
        checkOutput("reset_stall_cycles", stall_cycles, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Table: priority of stall / branch / load-use
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].in);
            @(negedge clk);
            checkOutput($sformatf("vec%0d_en", i), 32'(enBits()), 32'(vecs[i].en));
            checkOutput($sformatf("vec%0d_flush", i), 32'(flBits()), 32'(vecs[i].fl));
            checkOutput($sformatf("vec%0d_sel", i), 32'(pc_sel_branch), 32'(vecs[i].sel));
        end

        // Memory wait: three stalled cycles then ready
        for (int k = 0; k < 3; k++) begin
            applyStimulus(stall);
            @(negedge clk);
            checkOutput($sformatf("mw%0d_state", k), 32'(state), (k == 0) ? 32'd0 : 32'd1);
            checkOutput($sformatf("mw%0d_cnt", k), 32'(dut.wait_cnt), 32'(k));
            checkOutput($sformatf("mw%0d_en", k), 32'(enBits()), 32'h0);
        end
        applyStimulus(mkIn(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1));
        @(negedge clk);
        checkOutput("mw_ready_state", 32'(state), 32'd1);
        checkOutput("mw_ready_cnt", 32'(dut.wait_cnt), 32'd3);
        checkOutput("mw_ready_en", 32'(enBits()), 32'hF);
        applyStimulus(idle);
        @(negedge clk);
        checkOutput("mw_back_state", 32'(state), 32'd0);
        checkOutput("mw_back_cnt", 32'(dut.wait_cnt), 32'd0);

        // Watchdog: memory never answers
        for (int k = 1; k <= 9; k++) begin
            applyStimulus(stall);
            @(negedge clk);
            checkOutput($sformatf("to%0d_state", k), 32'(state),
                        (k == 1) ? 32'd0 : ((k == 9) ? 32'd2 : 32'd1));
            checkOutput($sformatf("to%0d_flag", k), 32'(mem_timeout), (k == 9) ? 32'd1 : 32'd0);
        end
        for (int k = 0; k < 2; k++) begin
            applyStimulus(mkIn(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1));
            @(negedge clk);
            checkOutput($sformatf("halt%0d_state", k), 32'(state), 32'd2);
            checkOutput($sformatf("halt%0d_en", k), 32'(enBits()), 32'h0);
            checkOutput($sformatf("halt%0d_flush", k), 32'(flBits()), 32'h1);
            checkOutput($sformatf("halt%0d_sel_to", k), 32'({pc_sel_branch, mem_timeout}), 32'd1);
        end

        // Reset leaves HALT immediately
        #2;
        rst_n = 1'b0;
        driveInputs(idle);
        #1;
        checkOutput("halt_rst_state", 32'(state), 32'd0);
        checkOutput("halt_rst_timeout", 32'(mem_timeout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Async reset in the middle of MEM_WAIT
        applyStimulus(stall);
        applyStimulus(stall);
        @(negedge clk);
        checkOutput("pre_rst_state", 32'(state), 32'd1);
        #2;
        rst_n = 1'b0;
        driveInputs(idle);
        #1;
        checkOutput("midrst_state", 32'(state), 32'd0);
        checkOutput("midrst_flush", 32'(flBits()), 32'hF);
        checkOutput("midrst_en", 32'(enBits()), 32'h0);
        checkOutput("midrst_cnt", 32'(dut.wait_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(idle);
        @(negedge clk);
        checkOutput("postrst_state", 32'(state), 32'd0);
        checkOutput("postrst_cnt", 32'(dut.wait_cnt), 32'd0);
        checkOutput("postrst_en", 32'(enBits()), 32'hF);

        // One load-use stall plus three memory-stall cycles
        applyStimulus(lu);
        @(negedge clk);
        checkOutput("cnt_lu_en", 32'(enBits()), 32'b0011);
        for (int k = 0; k < 3; k++) applyStimulus(stall);
        applyStimulus(mkIn(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1));
        applyStimulus(idle);
        @(negedge clk);
        checkOutput("cnt_end_state", 32'(state), 32'd0);
`ifdef STALL_CNT_EN
        checkOutput("stall_cycles", stall_cycles, 32'd4);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", compares, fails);
        $finish;
    end

endmodule
